if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage that sits directly upstream of the icache controller. Each cycle it drives a group of `WAYS` consecutive PCs into the icache read ports, and takes back the returned 64-bit lines and per-way valid bits. From these it selects the 32-bit instruction for each way and registers the longest all-hit in-order prefix into the IF/ID pipeline register. It owns the PC register, redirect handling, downstream stall and a miss-cycle counter.

## Interface
- `WAYS`, default 3: fetch width; equals the machine-wide `WAYS`.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clock` input, 1: single clock; all state updates on rising edge.
- `reset` input, 1: asynchronous, active-low (asserted at 0).
- `redirect_en` input, 1: branch/exception redirect from back end.
- `redirect_pc` input, 32: redirect target; bits [1:0] ignored (treated as 0).
- `id_stall` input, 1: decode cannot accept; IF/ID register must hold.
- `Icache_data_out` input, `WAYS`x64: line for each way's address.
- `Icache_valid_out` input, `WAYS`: per-way hit.
- `proc2Icache_addr` output, `WAYS`x32: `pc_reg + 4*i` for way i.
- `proc2Icache_en` output, `WAYS`: read enable per way.
- `if_id_pc` output, `WAYS`x32: registered PC per way.
- `if_id_inst` output, `WAYS`x32: registered instruction per way.
- `if_id_valid` output, `WAYS`: registered valid per way; always a contiguous prefix from way 0.
- `fetch_miss_cycles` output, 32: saturating count of cycles where way 0 missed.

## Operation
- Request: `proc2Icache_addr[i] = pc_reg + 4*i` (mod 2^32). `proc2Icache_en[i] = 1` when not in reset, `redirect_en` is 0 and `id_stall` is 0; otherwise 0. Requests are not issued during a stall, so the controller launches no refills for a group that cannot advance.
- Selection: `inst[i] = addr[i][2] ? data[i][63:32] : data[i][31:0]`.
- Hit prefix: `hit[i] = AND(Icache_valid_out[0..i])`. `n` = number of set bits in `hit`, range 0..`WAYS`.
- Next PC, in priority order:
  - `redirect_en`: `pc_reg <= {redirect_pc[31:2],2'b0}`.
  - `id_stall`: hold.
  - Otherwise: `pc_reg <= pc_reg + 4*n`.
- Because `n = 0` on a way-0 miss, the PC stays put and the same address keeps being presented until the icache controller's refill makes it hit.
- IF/ID register, in priority order:
  - `redirect_en`: all `if_id_valid <= 0`; PC and instruction fields are don't-care.
  - `id_stall`: hold all fields.
  - Otherwise: `if_id_valid <= hit`, `if_id_pc[i] <= addr[i]`, `if_id_inst[i] <= inst[i]`.
- Ways beyond the prefix are invalid even if their own hit bit is 1; fetch is strictly in order.
- Counter: `fetch_miss_cycles` increments when `proc2Icache_en[0] & ~Icache_valid_out[0]`. It saturates at 32'hFFFF_FFFF and is never cleared except by reset.

## Timing
- Combinational path: `pc_reg` to `proc2Icache_addr`/`en`; icache valid/data to next-state logic. There is no combinational path from icache inputs to any output.
- Latency: an address presented in cycle t appears on `if_id_*` in cycle t+1 if hit and not stalled.
- Redirect asserted in cycle t:
  - `pc_reg = redirect_pc` and `if_id_valid = 0` in t+1.
  - The first fetch of the target is presented in t+1, and that group appears in t+2 at the earliest.
- Redirect and stall together: redirect wins; the IF/ID register is flushed even while stalled.
- PC wrap: `32'hFFFF_FFFC + 4` wraps to 0 with no special handling.
- Reset asserted (async, any cycle, including mid-miss):
  - `pc_reg = RESET_PC`, `if_id_valid = 0`, `if_id_pc = 0`, `if_id_inst = 0`, `fetch_miss_cycles = 0`.
  - `proc2Icache_en = 0` while reset is held.
  - Fetch resumes at `RESET_PC` on the first edge after deassertion.

## Structure
- Shared package holds: `XLEN = 32`, `INST_W = 32`, `LINE_W = 64`, and an `if_id_packet_t` struct {pc, inst, valid}.
- `WAYS` stays the global macro; the parameter defaults to it.
- One sub-module is natural: `if_id_reg`, the `WAYS`-wide packet register with hold and flush, shared later by other pipeline registers.

## Test plan
- Reset hit run: release reset, all ways hit for 3 cycles, `WAYS=3` -> `if_id_pc` = {0,4,8}, {C,10,14}, {18,1C,20}; `pc_reg` advances by 12 each cycle.
- Partial hit: `pc_reg=0x40`, valid=3'b101 -> `if_id_valid=3'b001`, next `pc_reg=0x44`; instruction for 0x44 taken from bits [63:32].
- Way-0 miss for 5 cycles, then hit -> PC held at the miss address, `if_id_valid=0` during the miss, `fetch_miss_cycles` increases by 5.
- Stall plus redirect: `id_stall=1` for 2 cycles holds outputs; assert `redirect_en` with `redirect_pc=0x1003` while stalled -> next cycle `if_id_valid=0`, `proc2Icache_addr[0]=0x1000`.
- Async reset mid-run at `pc_reg=0x200` with valid outputs -> all outputs 0 immediately without a clock edge; after release, fetch restarts at `RESET_PC`.
- Wrap: `pc_reg=0xFFFF_FFF8`, all hit -> addresses {FFF8, FFFC, 0000_0000}, next `pc_reg=0x4`.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-path types: widths, the IF/ID packet, and the half-line select helper.
`ifndef WAYS
`define WAYS 3
`endif

package if_stage_pkg;
   localparam int XLEN   = 32;
   localparam int INST_W = 32;
   localparam int LINE_W = 64;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
      logic              valid;
   } if_id_packet_t;

   // A 64-bit line holds two instructions; address bit 2 picks the half.
   function automatic logic [INST_W-1:0] select_inst(input logic upper,
                                                     input logic [LINE_W-1:0] line);
      return upper ? line[LINE_W-1:INST_W] : line[INST_W-1:0];
   endfunction
endpackage

// File: rtl/if_id_reg.sv
// WAYS-wide IF/ID packet register; flush clears valids and takes priority over hold.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int WAYS = `WAYS
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     hold,
   input  if_id_packet_t [WAYS-1:0] pkt_in,
   output if_id_packet_t [WAYS-1:0] pkt_out
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pkt_out <= '0;
      end else if (flush) begin
         for (int i = 0; i < WAYS; i++) begin
            pkt_out[i].valid <= 1'b0;
         end
      end else if (!hold) begin
         pkt_out <= pkt_in;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: issues WAYS sequential PCs to the icache and latches the in-order hit prefix.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int              WAYS     = `WAYS,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         redirect_en,
   input  logic [XLEN-1:0]              redirect_pc,
   input  logic                         id_stall,
   input  logic [WAYS-1:0][LINE_W-1:0]  Icache_data_out,
   input  logic [WAYS-1:0]              Icache_valid_out,
   output logic [WAYS-1:0][XLEN-1:0]    proc2Icache_addr,
   output logic [WAYS-1:0]              proc2Icache_en,
   output logic [WAYS-1:0][XLEN-1:0]    if_id_pc,
   output logic [WAYS-1:0][INST_W-1:0]  if_id_inst,
   output logic [WAYS-1:0]              if_id_valid,
   output logic [XLEN-1:0]              fetch_miss_cycles
);

   logic [XLEN-1:0]          pc_reg;
   logic [XLEN-1:0]          pc_next;
   logic [XLEN-1:0]          advance;
   logic [WAYS-1:0]          hit;
   logic                     fetch_go;
   logic                     unused_low_bits;
   if_id_packet_t [WAYS-1:0] pkt_next;
   if_id_packet_t [WAYS-1:0] pkt_q;

   assign unused_low_bits = &redirect_pc[1:0];

   // No requests during a stall so the icache never refills for a group that cannot advance.
   assign fetch_go = reset & ~redirect_en & ~id_stall;

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign proc2Icache_addr[gi] = pc_reg + XLEN'(4 * gi);
         assign proc2Icache_en[gi]   = fetch_go;
         assign pkt_next[gi] = {proc2Icache_addr[gi],
                                select_inst(proc2Icache_addr[gi][2], Icache_data_out[gi]),
                                hit[gi]};
         assign if_id_pc[gi]    = pkt_q[gi].pc;
         assign if_id_inst[gi]  = pkt_q[gi].inst;
         assign if_id_valid[gi] = pkt_q[gi].valid;
      end
   endgenerate

   // A way counts only if every earlier way also hit: fetch stays strictly in order.
   always_comb begin
      logic run;
      hit     = '0;
      advance = '0;
      run     = 1'b1;
      for (int i = 0; i < WAYS; i++) begin
         run    = run & Icache_valid_out[i];
         hit[i] = run;
         if (run) begin
            advance = advance + XLEN'(4);
         end
      end
   end

   always_comb begin
      pc_next = pc_reg;
      if (redirect_en) begin
         pc_next = {redirect_pc[XLEN-1:2], 2'b00};
      end else if (!id_stall) begin
         pc_next = pc_reg + advance;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_reg <= RESET_PC;
      end else begin
         pc_reg <= pc_next;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_miss_cycles <= '0;
      end else if (proc2Icache_en[0] && !Icache_valid_out[0] && (fetch_miss_cycles != '1)) begin
         fetch_miss_cycles <= fetch_miss_cycles + 1'b1;
      end
   end

   if_id_reg #(
      .WAYS(WAYS)
   ) u_if_id_reg (
      .clock  (clock),
      .reset  (reset),
      .flush  (redirect_en),
      .hold   (id_stall),
      .pkt_in (pkt_next),
      .pkt_out(pkt_q)
   );

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed check of if_stage against a behavioural fetch model.
module tb_if_stage;
   localparam int          WAYS     = 3;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic                   clock;
   logic                   rst_n;
   logic                   redirect_en;
   logic [31:0]            redirect_pc;
   logic                   id_stall;
   logic [WAYS-1:0][63:0]  Icache_data_out;
   logic [WAYS-1:0]        Icache_valid_out;
   logic [WAYS-1:0][31:0]  proc2Icache_addr;
   logic [WAYS-1:0]        proc2Icache_en;
   logic [WAYS-1:0][31:0]  if_id_pc;
   logic [WAYS-1:0][31:0]  if_id_inst;
   logic [WAYS-1:0]        if_id_valid;
   logic [31:0]            fetch_miss_cycles;

   if_stage #(.WAYS(WAYS), .RESET_PC(RESET_PC)) dut (
      .clock            (clock),
      .reset            (rst_n),
      .redirect_en      (redirect_en),
      .redirect_pc      (redirect_pc),
      .id_stall         (id_stall),
      .Icache_data_out  (Icache_data_out),
      .Icache_valid_out (Icache_valid_out),
      .proc2Icache_addr (proc2Icache_addr),
      .proc2Icache_en   (proc2Icache_en),
      .if_id_pc         (if_id_pc),
      .if_id_inst       (if_id_inst),
      .if_id_valid      (if_id_valid),
      .fetch_miss_cycles(fetch_miss_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit check_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: PC, the latched group, and the miss count.
   logic [31:0]     m_pc;
   logic [WAYS-1:0] m_valid;
   logic [31:0]     m_pc_q   [WAYS];
   logic [31:0]     m_inst_q [WAYS];
   bit              m_known;
   logic [31:0]     m_miss;
   int              m_n;
   logic [31:0]     m_a;

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_pc    = RESET_PC;
         m_valid = '0;
         m_known = 1'b1;
         m_miss  = 32'd0;
         for (int i = 0; i < WAYS; i++) begin
            m_pc_q[i]   = 32'd0;
            m_inst_q[i] = 32'd0;
         end
      end else begin
         m_n = 0;
         while (m_n < WAYS && Icache_valid_out[m_n]) m_n++;
         if (!redirect_en && !id_stall && !Icache_valid_out[0] && m_miss != 32'hFFFF_FFFF)
            m_miss = m_miss + 32'd1;
         if (redirect_en) begin
            m_valid = '0;
            m_known = 1'b0;
            m_pc    = {redirect_pc[31:2], 2'b00};
         end else if (!id_stall) begin
            for (int i = 0; i < WAYS; i++) begin
               m_a         = m_pc + 32'(4 * i);
               m_pc_q[i]   = m_a;
               m_inst_q[i] = m_a[2] ? Icache_data_out[i][63:32] : Icache_data_out[i][31:0];
            end
            m_valid = WAYS'((1 << m_n) - 1);
            m_pc    = m_pc + 32'(4 * m_n);
            m_known = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (check_on) begin
         for (int i = 0; i < WAYS; i++) begin
            chk($sformatf("addr[%0d]", i), proc2Icache_addr[i], m_pc + 32'(4 * i));
            chk($sformatf("en[%0d]", i), 32'(proc2Icache_en[i]),
                32'(rst_n & ~redirect_en & ~id_stall));
            chk($sformatf("valid[%0d]", i), 32'(if_id_valid[i]), 32'(m_valid[i]));
            if (m_known) begin
               chk($sformatf("if_id_pc[%0d]", i), if_id_pc[i], m_pc_q[i]);
               chk($sformatf("if_id_inst[%0d]", i), if_id_inst[i], m_inst_q[i]);
            end
         end
         chk("miss_cycles", fetch_miss_cycles, m_miss);
      end
   end

   // Drive one cycle of inputs, then return just after the following falling edge.
   task automatic step(input logic re, input logic [31:0] rpc, input logic st,
                       input logic [WAYS-1:0] v);
      redirect_en      = re;
      redirect_pc      = rpc;
      id_stall         = st;
      Icache_valid_out = v;
      for (int i = 0; i < WAYS; i++) Icache_data_out[i] = {$urandom, $urandom};
      @(negedge clock);
      #1;
   endtask

   logic [31:0] snap;
   logic [31:0] hi_word;
   logic [WAYS-1:0] rv;

   initial begin
      rst_n            = 1'b0;
      redirect_en      = 1'b0;
      redirect_pc      = 32'd0;
      id_stall         = 1'b0;
      Icache_valid_out = '0;
      Icache_data_out  = '0;
      repeat (2) @(negedge clock);
      #1;
      check_on = 1'b1;
      chk("reset_valid", 32'(if_id_valid), 32'd0);
      chk("reset_en", 32'(proc2Icache_en), 32'd0);
      chk("reset_addr0", proc2Icache_addr[0], RESET_PC);
      rst_n = 1'b1;

      // Reset hit run
      step(1'b0, 32'd0, 1'b0, '1);
      chk("run1_pc0", if_id_pc[0], 32'h0); chk("run1_pc2", if_id_pc[2], 32'h8);
      step(1'b0, 32'd0, 1'b0, '1);
      chk("run2_pc0", if_id_pc[0], 32'hC); chk("run2_pc2", if_id_pc[2], 32'h14);
      step(1'b0, 32'd0, 1'b0, '1);
      chk("run3_pc0", if_id_pc[0], 32'h18); chk("run3_pc2", if_id_pc[2], 32'h20);
      chk("run3_addr0", proc2Icache_addr[0], 32'h24);

      // Partial hit at 0x40
      step(1'b1, 32'h40, 1'b0, '1);
      chk("redir_valid", 32'(if_id_valid), 32'd0);
      chk("redir_addr0", proc2Icache_addr[0], 32'h40);
      step(1'b0, 32'd0, 1'b0, 3'b101);
      chk("partial_valid", 32'(if_id_valid), 32'b001);
      chk("partial_next_pc", proc2Icache_addr[0], 32'h44);
      step(1'b0, 32'd0, 1'b0, '1);
      hi_word = Icache_data_out[0][63:32];
      chk("upper_half_inst", if_id_inst[0], hi_word);
      chk("upper_half_pc", if_id_pc[0], 32'h44);

      // Way-0 miss for five cycles
      snap = m_miss;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 32'd0, 1'b0, 3'b110);
         chk("miss_valid", 32'(if_id_valid), 32'd0);
         chk("miss_hold_pc", proc2Icache_addr[0], 32'h50);
      end
      chk("miss_count_plus5", fetch_miss_cycles, snap + 32'd5);
      step(1'b0, 32'd0, 1'b0, '1);
      chk("miss_then_hit_pc0", if_id_pc[0], 32'h50);

      // Stall, then redirect while stalled
      step(1'b0, 32'd0, 1'b1, '1);
      step(1'b0, 32'd0, 1'b1, '1);
      chk("stall_hold_pc0", if_id_pc[0], 32'h50);
      chk("stall_hold_valid", 32'(if_id_valid), 32'b111);
      chk("stall_en", 32'(proc2Icache_en), 32'd0);
      step(1'b1, 32'h1003, 1'b1, '1);
      chk("stall_redir_valid", 32'(if_id_valid), 32'd0);
      chk("stall_redir_addr0", proc2Icache_addr[0], 32'h1000);
      step(1'b0, 32'd0, 1'b0, '1);
      chk("target_pc0", if_id_pc[0], 32'h1000);

      // Async reset mid-run
      step(1'b1, 32'h200, 1'b0, '1);
      step(1'b0, 32'd0, 1'b0, '1);
      chk("pre_reset_valid", 32'(if_id_valid), 32'b111);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(if_id_valid), 32'd0);
      chk("async_pc0", if_id_pc[0], 32'd0);
      chk("async_inst0", if_id_inst[0], 32'd0);
      chk("async_miss", fetch_miss_cycles, 32'd0);
      chk("async_addr0", proc2Icache_addr[0], RESET_PC);
      chk("async_en", 32'(proc2Icache_en), 32'd0);
      @(negedge clock);
      #1 rst_n = 1'b1;
      step(1'b0, 32'd0, 1'b0, '1);
      chk("restart_pc0", if_id_pc[0], RESET_PC);

      // PC wrap
      step(1'b1, 32'hFFFF_FFF8, 1'b0, '1);
      chk("wrap_addr0", proc2Icache_addr[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", proc2Icache_addr[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", proc2Icache_addr[2], 32'h0000_0000);
      step(1'b0, 32'd0, 1'b0, '1);
      chk("wrap_next_pc", proc2Icache_addr[0], 32'h4);
      chk("wrap_if_id_pc2", if_id_pc[2], 32'h0);

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         rv = WAYS'($urandom);
         if ($urandom_range(0, 3) != 0) rv[0] = 1'b1;
         step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 6) == 0, rv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
